// File: rtl/seg_scan_mux_pkg.sv
// Shared constants, state encoding and anode helper for the 4-digit
// seven-segment scanner.
package seg_scan_mux_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 4'b1111;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } scan_state_e;

    // Active-low enable for one digit; a blanked digit stays dark.
    function automatic logic [NUM_DIGITS-1:0] digit_enable(
        input logic [1:0] idx,
        input logic       blank
    );
        logic [NUM_DIGITS-1:0] onehot;
        onehot = 4'b0001 << idx;
        return blank ? ANODES_OFF : ~onehot;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot timer: counts 0..REFRESH_DIV-1 and flags the last cycle of
// each slot with tick.
module scan_tick_gen #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(REFRESH_DIV)-1:0] slot_cnt,
    output logic                           tick
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    logic [CW-1:0] slot_cnt_q;
    logic [CW-1:0] slot_cnt_d;

    always_comb begin
        slot_cnt_d = slot_cnt_q + CW'(1);
        if (slot_cnt_q == LAST) begin
            slot_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign slot_cnt = slot_cnt_q;
    assign tick     = (slot_cnt_q == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed 4-digit common-anode scanner with frame-synchronous
// double-buffered value updates.
module seg_scan_mux
    import seg_scan_mux_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    output logic [3:0]  nibble,
    output logic [3:0]  T,
    output logic [1:0]  digit_idx,
    output logic        frame_start,
    output logic        load_ack
);

    localparam int unsigned CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);

    logic [CW-1:0] slot_cnt;
    logic          tick;
    logic          wrap;

    scan_state_e   state_q, state_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    t_q, t_d;
    logic [3:0]    nibble_q, nibble_d;
    logic [15:0]   active_q, active_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          frame_start_q, frame_start_d;
    logic          load_ack_q, load_ack_d;

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .slot_cnt (slot_cnt),
        .tick     (tick)
    );

    assign wrap = tick && (digit_q == 2'd3);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_DEAD:  if (slot_cnt == DEAD_LAST) state_d = S_ON;
            S_ON:    if (tick) state_d = S_DEAD;
            default: state_d = S_DEAD;
        endcase
    end

    always_comb begin
        digit_d       = tick ? digit_q + 2'd1 : digit_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;
        active_d      = active_q;
        load_ack_d    = 1'b0;
        frame_start_d = wrap;

        // Commit uses the pre-load shadow; a coincident load re-arms pending.
        if (wrap && pending_q) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            load_ack_d = 1'b1;
        end
        if (load) begin
            shadow_d  = value;
            pending_d = 1'b1;
        end

        // Built from next-cycle values so T, nibble and digit_idx move together.
        nibble_d = active_d[{digit_d, 2'b00} +: 4];
        t_d      = (state_d == S_ON) ? digit_enable(digit_d, blank_mask[digit_d])
                                     : ANODES_OFF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_DEAD;
            digit_q       <= '0;
            t_q           <= ANODES_OFF;
            nibble_q      <= '0;
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            load_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            digit_q       <= digit_d;
            t_q           <= t_d;
            nibble_q      <= nibble_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            load_ack_q    <= load_ack_d;
        end
    end

    assign nibble      = nibble_q;
    assign T           = t_q;
    assign digit_idx   = digit_q;
    assign frame_start = frame_start_q;
    assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux with REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_seg_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank_mask;
    logic [3:0]  nibble;
    logic [3:0]  T;
    logic [1:0]  digit_idx;
    logic        frame_start;
    logic        load_ack;

    int unsigned checks;
    int unsigned failures;
    int unsigned cyc;
    int unsigned ack_seen;
    int unsigned nib4_seen;
    int unsigned lit_seen;

    seg_scan_mux #(
        .REFRESH_DIV (8),
        .DEAD_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .value       (value),
        .blank_mask  (blank_mask),
        .nibble      (nibble),
        .T           (T),
        .digit_idx   (digit_idx),
        .frame_start (frame_start),
        .load_ack    (load_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to cycle 'target' counted in rising edges since reset release;
    // sample 1 time unit after each edge.
    task automatic step_to(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
            cyc++;
            if (load_ack === 1'b1) ack_seen++;
            if (nibble === 4'h4) nib4_seen++;
            if (T !== 4'b1111) lit_seen++;
        end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        ack_seen = 0; nib4_seen = 0; lit_seen = 0;
        rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0;

        // 1. reset and scan rotation
        #12;
        chk("rst_T", 16'(T), 16'hF);
        chk("rst_nibble", 16'(nibble), 16'h0);
        chk("rst_digit", 16'(digit_idx), 16'h0);
        chk("rst_fs_ack", 16'({frame_start, load_ack}), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; cyc = 0;
        step_to(1);  chk("c1_T_dark", 16'(T), 16'hF);
        step_to(2);  chk("c2_T_d0", 16'(T), 16'hE);
        step_to(7);  chk("c7_T_d0", 16'(T), 16'hE);
        step_to(8);  chk("c8_T_dead", 16'(T), 16'hF);
        chk("c8_digit", 16'(digit_idx), 16'h1);
        step_to(9);  chk("c9_T_dead", 16'(T), 16'hF);
        step_to(10); chk("c10_T_d1", 16'(T), 16'hD);
        step_to(18); chk("c18_T_d2", 16'(T), 16'hB);
        step_to(26); chk("c26_T_d3", 16'(T), 16'h7);
        step_to(31); chk("c31_fs_low", 16'(frame_start), 16'h0);
        step_to(32); chk("c32_fs", 16'(frame_start), 16'h1);
        chk("c32_no_ack", 16'(load_ack), 16'h0);
        chk("c32_digit", 16'(digit_idx), 16'h0);
        step_to(33); chk("c33_fs_low", 16'(frame_start), 16'h0);

        // 2. load mid-frame, commit at next wrap
        step_to(40);
        load = 1'b1; value = 16'hBEEF;
        step_to(41);
        load = 1'b0;
        step_to(50); chk("t2_hold_nib", 16'(nibble), 16'h0);
        ack_seen = 0;
        step_to(63); chk("t2_no_early_ack", 16'(ack_seen), 16'h0);
        step_to(64); chk("t2_ack", 16'(load_ack), 16'h1);
        chk("t2_fs", 16'(frame_start), 16'h1);
        chk("t2_nib0", 16'(nibble), 16'hF);
        step_to(65); chk("t2_ack_pulse", 16'(load_ack), 16'h0);
        step_to(66); chk("t2_T_d0", 16'(T), 16'hE);
        step_to(72); chk("t2_nib1", 16'(nibble), 16'hE);
        step_to(80); chk("t2_nib2", 16'(nibble), 16'hE);
        step_to(88); chk("t2_nib3", 16'(nibble), 16'hB);

        // 3. two loads in one frame: last wins, single ack
        step_to(100);
        load = 1'b1; value = 16'h1234;
        step_to(101);
        load = 1'b0;
        step_to(110);
        load = 1'b1; value = 16'h5678;
        step_to(111);
        load = 1'b0;
        ack_seen = 0; nib4_seen = 0;
        step_to(128); chk("t3_ack", 16'(load_ack), 16'h1);
        chk("t3_nib0", 16'(nibble), 16'h8);
        step_to(136); chk("t3_nib1", 16'(nibble), 16'h7);
        step_to(144); chk("t3_nib2", 16'(nibble), 16'h6);
        step_to(152); chk("t3_nib3", 16'(nibble), 16'h5);
        step_to(159);
        chk("t3_one_ack", 16'(ack_seen), 16'h1);
        chk("t3_no_1234", 16'(nib4_seen), 16'h0);

        // 4. blank digit 3
        step_to(160);
        blank_mask = 4'b1000;
        step_to(170); chk("t4_T_d1", 16'(T), 16'hD);
        step_to(178); chk("t4_T_d2", 16'(T), 16'hB);
        step_to(183);
        lit_seen = 0;
        step_to(186);
        chk("t4_digit3", 16'(digit_idx), 16'h3);
        chk("t4_nib3", 16'(nibble), 16'h5);
        step_to(191);
        chk("t4_slot_dark", 16'(lit_seen), 16'h0);
        step_to(192);
        blank_mask = 4'b0000;
        step_to(194); chk("t4_T_d0", 16'(T), 16'hE);

        // 5. asynchronous reset mid S_ON
        step_to(196);
        chk("t5_pre_T", 16'(T), 16'hE);
        chk("t5_pre_nib", 16'(nibble), 16'h8);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_T", 16'(T), 16'hF);
        chk("t5_async_nib", 16'(nibble), 16'h0);
        chk("t5_async_fs_ack", 16'({frame_start, load_ack}), 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; cyc = 0;
        step_to(2);
        chk("t5_restart_T", 16'(T), 16'hE);
        chk("t5_restart_digit", 16'(digit_idx), 16'h0);
        chk("t5_active_clear", 16'(nibble), 16'h0);

        // 6. load on commit cycle with pending=0
        step_to(31);
        load = 1'b1; value = 16'hA5A5;
        step_to(32);
        load = 1'b0;
        chk("t6_fs", 16'(frame_start), 16'h1);
        chk("t6_no_ack", 16'(load_ack), 16'h0);
        chk("t6_nib_old", 16'(nibble), 16'h0);
        ack_seen = 0;
        step_to(63); chk("t6_no_early_ack", 16'(ack_seen), 16'h0);
        step_to(64); chk("t6_ack", 16'(load_ack), 16'h1);
        chk("t6_nib0", 16'(nibble), 16'h5);
        step_to(72); chk("t6_nib1", 16'(nibble), 16'hA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
